key_schedule_ctrl: RTL and testbench

Sequential AES key-schedule controller. It accepts a cipher key through a valid/ready handshake and iterates one shared `key_expansion` instance, one Nk-word group per clock. Results go into an internal round-key store, which the round engine then reads one 128-bit round key at a time. It sits between the key-load path and the cipher/inverse-cipher round datapath, and replaces the fully unrolled combinational key generator wherever area matters.

---
 rtl/aes_pkg.sv | 77 +++++++
 rtl/key_expansion.sv | 36 +++
 rtl/key_schedule_ctrl.sv | 161 ++++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the sequential key-schedule controller:
// controller state encoding, schedule sizing helpers, read-port widths
// and the byte-level GF(2^8) helpers used by the key expansion step.
package aes_pkg;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_READY  = 2'd2
  } ksState_e;

  localparam int RD_IDX_W = 4;
  localparam int RK_W     = 128;

  // Number of cipher rounds for a key of nk 32-bit words.
  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  // Number of Nk-word groups generated after the cipher key itself.
  function automatic int steps_of(input int nk);
    int words;
    words = 4 * (nr_of(nk) + 1);
    return (words + nk - 1) / nk - 1;
  endfunction

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      if (aa[7]) aa = (aa << 1) ^ 8'h1b;
      else       aa = aa << 1;
    end
    return p;
  endfunction

  // AES S-box: multiplicative inverse (x^254, so 0 maps to 0) then affine map.
  function automatic logic [7:0] sBox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gfMul(sq, sq);
      inv = gfMul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sBox(w[31:24]), sBox(w[23:16]), sBox(w[15:8]), sBox(w[7:0])};
  endfunction

  // Round constant for the first word of group r (r = 1..10).
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_expansion.sv
// One key-expansion step: derives the next Nk-word group of the AES key
// schedule from the previous group and the group number (round).
module key_expansion
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic [0:Nk*32-1] prevGroup,
  input  logic [3:0]       round,
  output logic [0:Nk*32-1] nextGroup
);

  localparam int MAX_ROUND = (4 * (Nr + 1) + Nk - 1) / Nk - 1;

  logic [7:0] rconByte_s;

  assign rconByte_s = (int'(round) <= MAX_ROUND) ? rcon(round) : 8'h00;

  // Word chain: word j = prev word j xor the (transformed) previously produced word.
  always_comb begin
    logic [31:0] temp;
    logic [31:0] w;
    nextGroup = '0;
    temp = prevGroup[(Nk-1)*32 +: 32];
    for (int j = 0; j < Nk; j++) begin
      if (j == 0)                temp = subWord({temp[23:0], temp[31:24]}) ^ {rconByte_s, 24'h000000};
      else if (Nk > 6 && j == 4) temp = subWord(temp);
      else                       temp = temp;
      w = prevGroup[j*32 +: 32] ^ temp;
      nextGroup[j*32 +: 32] = w;
      temp = w;
    end
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// Sequential AES key-schedule controller: accepts a key, runs one shared
// key_expansion step per clock into a word store, then serves 128-bit
// round keys with one-cycle read latency.
// Optional feature macro KEY_SCHED_ZEROIZE_EN adds a zeroize input that
// wipes the word store and read data and returns the controller to IDLE.
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef KEY_SCHED_ZEROIZE_EN
  input  logic                zeroize,
`endif
  input  logic [0:Nk*32-1]    key_in,
  input  logic                key_valid,
  output logic                key_ready,
  output logic                busy,
  output logic                done,
  output logic                keys_ready,
  input  logic                rd_en,
  input  logic [RD_IDX_W-1:0] rd_idx,
  output logic [0:RK_W-1]     rd_data,
  output logic                rd_valid
);

  localparam int STEPS     = steps_of(Nk);
  localparam int NUM_WORDS = (STEPS + 1) * Nk;

  localparam logic [1:0] IDLE   = KS_IDLE;
  localparam logic [1:0] EXPAND = KS_EXPAND;
  localparam logic [1:0] READY  = KS_READY;

  logic [1:0]       stateR, nextState_s;
  logic [3:0]       stepR, nextStep_s;
  logic             keyReadyR, busyR, doneR, keysReadyR, rdValidR;
  logic [0:RK_W-1]  rdDataR;
  logic [31:0]      wordsR [0:NUM_WORDS-1];
  logic [0:Nk*32-1] prevGroup_s, nextGroup_s;
  logic             accept_s, lastStep_s, writeStep_s, zeroize_s;

`ifdef KEY_SCHED_ZEROIZE_EN
  assign zeroize_s = zeroize;
`else
  assign zeroize_s = 1'b0;
`endif

  assign accept_s    = key_valid && keyReadyR;
  // Steps 1..STEPS write a group; step STEPS+1 is the closing cycle.
  assign writeStep_s = (stateR == EXPAND) && (int'(stepR) <= STEPS);
  assign lastStep_s  = (stateR == EXPAND) && (int'(stepR) == STEPS + 1);

  key_expansion #(.Nk(Nk), .Nr(Nr)) u_keyExpansion (
    .prevGroup (prevGroup_s),
    .round     (stepR),
    .nextGroup (nextGroup_s)
  );

  // Select group[step-1] from the store as the expansion input.
  always_comb begin
    int base;
    prevGroup_s = '0;
    if (stepR == 4'd0) base = 0;
    else               base = (int'(stepR) - 1) * Nk;
    for (int j = 0; j < Nk; j++) begin
      if (base + j < NUM_WORDS) prevGroup_s[j*32 +: 32] = wordsR[base + j];
      else                      prevGroup_s[j*32 +: 32] = 32'h00000000;
    end
  end

  // Next-state and step-counter logic; zeroize overrides a handshake.
  always_comb begin
    nextState_s = stateR;
    nextStep_s  = stepR;
    if (zeroize_s) begin
      nextState_s = IDLE;
      nextStep_s  = 4'd0;
    end else begin
      case (stateR)
        IDLE, READY: begin
          if (accept_s) begin
            nextState_s = EXPAND;
            nextStep_s  = 4'd1;
          end else begin
            nextState_s = stateR;
            nextStep_s  = stepR;
          end
        end
        EXPAND: begin
          if (lastStep_s) begin
            nextState_s = READY;
            nextStep_s  = 4'd0;
          end else begin
            nextState_s = EXPAND;
            nextStep_s  = stepR + 4'd1;
          end
        end
        default: begin
          nextState_s = IDLE;
          nextStep_s  = 4'd0;
        end
      endcase
    end
  end

  // Controller state, step counter and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR     <= IDLE;
      stepR      <= 4'd0;
      keyReadyR  <= 1'b1;
      busyR      <= 1'b0;
      doneR      <= 1'b0;
      keysReadyR <= 1'b0;
    end else begin
      stateR     <= nextState_s;
      stepR      <= nextStep_s;
      keyReadyR  <= (nextState_s != EXPAND);
      busyR      <= (nextState_s == EXPAND);
      doneR      <= lastStep_s && !zeroize_s;
      keysReadyR <= (nextState_s == READY);
    end
  end

  // Word store: key load into group 0, one expanded group per EXPAND cycle.
  always_ff @(posedge clk) begin
    if (zeroize_s) begin
      for (int k = 0; k < NUM_WORDS; k++) wordsR[k] <= 32'h00000000;
    end else if (accept_s) begin
      for (int j = 0; j < Nk; j++) wordsR[j] <= key_in[j*32 +: 32];
    end else if (writeStep_s) begin
      for (int j = 0; j < Nk; j++) wordsR[int'(stepR) * Nk + j] <= nextGroup_s[j*32 +: 32];
    end
  end

  // Round-key read port; the store is only visible while keys_ready is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdDataR  <= '0;
      rdValidR <= 1'b0;
    end else if (zeroize_s) begin
      rdDataR  <= '0;
      rdValidR <= 1'b0;
    end else if (rd_en && keysReadyR && (int'(rd_idx) <= Nr)) begin
      for (int k = 0; k < 4; k++) rdDataR[k*32 +: 32] <= wordsR[4 * int'(rd_idx) + k];
      rdValidR <= 1'b1;
    end else begin
      rdValidR <= 1'b0;
    end
  end

  assign key_ready  = keyReadyR;
  assign busy       = busyR;
  assign done       = doneR;
  assign keys_ready = keysReadyR;
  assign rd_data    = rdDataR;
  assign rd_valid   = rdValidR;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: three instances (Nk = 4, 6, 8) driven from a
// table of FIPS-197 key / round-key vectors, plus directed sequences for
// reload-with-read, reads during expansion, illegal index, reset abort and
// (with KEY_SCHED_ZEROIZE_EN) zeroize.
module tb_key_schedule_ctrl;

  localparam logic [255:0] KEY1   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY2   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY6   = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY8   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK10K1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK10K2 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    int           dut;
    logic [255:0] key;
    int           idx;
    logic [127:0] exp;
    int           doneAt;
  } vec_t;

  vec_t vecs [0:7];

  logic         clk;
  logic         rst_n;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic [2:0]   keyValid, rdEn;
  logic [3:0]   rdIdx [0:2];
  logic [2:0]   keyReadyV, busyV, doneV, keysReadyV, rdValidV;
  logic [127:0] rdData0, rdData1, rdData2;
`ifdef KEY_SCHED_ZEROIZE_EN
  logic [2:0]   zeroizeV;
`endif

  int           nAssert;
  int           nFail;
  int           cnt;
  bit           seen;
  logic         v;
  logic [127:0] data;

  key_schedule_ctrl #(.Nk(4), .Nr(10)) u4 (
    .clk(clk), .rst_n(rst_n),
`ifdef KEY_SCHED_ZEROIZE_EN
    .zeroize(zeroizeV[0]),
`endif
    .key_in(key4), .key_valid(keyValid[0]), .key_ready(keyReadyV[0]), .busy(busyV[0]),
    .done(doneV[0]), .keys_ready(keysReadyV[0]), .rd_en(rdEn[0]), .rd_idx(rdIdx[0]),
    .rd_data(rdData0), .rd_valid(rdValidV[0]));

  key_schedule_ctrl #(.Nk(6), .Nr(12)) u6 (
    .clk(clk), .rst_n(rst_n),
`ifdef KEY_SCHED_ZEROIZE_EN
    .zeroize(zeroizeV[1]),
`endif
    .key_in(key6), .key_valid(keyValid[1]), .key_ready(keyReadyV[1]), .busy(busyV[1]),
    .done(doneV[1]), .keys_ready(keysReadyV[1]), .rd_en(rdEn[1]), .rd_idx(rdIdx[1]),
    .rd_data(rdData1), .rd_valid(rdValidV[1]));

  key_schedule_ctrl #(.Nk(8), .Nr(14)) u8 (
    .clk(clk), .rst_n(rst_n),
`ifdef KEY_SCHED_ZEROIZE_EN
    .zeroize(zeroizeV[2]),
`endif
    .key_in(key8), .key_valid(keyValid[2]), .key_ready(keyReadyV[2]), .busy(busyV[2]),
    .done(doneV[2]), .keys_ready(keysReadyV[2]), .rd_en(rdEn[2]), .rd_idx(rdIdx[2]),
    .rd_data(rdData2), .rd_valid(rdValidV[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] getRd(input int d);
    case (d)
      0:       return rdData0;
      1:       return rdData1;
      default: return rdData2;
    endcase
  endfunction

  function automatic logic [4:0] status(input int d);
    return {keyReadyV[d], busyV[d], doneV[d], keysReadyV[d], rdValidV[d]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic setKey(input int d, input logic [255:0] k);
    case (d)
      0:       key4 = k[255:128];
      1:       key6 = k[255:64];
      default: key8 = k;
    endcase
  endtask

  // Handshake at edge T, then count edges until done; expect done at T+expCycles.
  task automatic loadKey(input int d, input logic [255:0] k, input int expCycles, input string tag);
    int  n;
    bit  got;
    @(negedge clk);
    setKey(d, k);
    keyValid[d] = 1'b1;
    @(posedge clk);
    #1;
    keyValid = 3'b000;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (doneV[d]) got = 1'b1;
    end
    check({tag, " done latency"}, 128'(n), 128'(expCycles));
    check({tag, " keys_ready"}, {127'd0, keysReadyV[d]}, 128'd1);
  endtask

  task automatic doRead(input int d, input int idx, output logic vOut, output logic [127:0] dOut);
    @(negedge clk);
    rdEn[d]  = 1'b1;
    rdIdx[d] = 4'(idx);
    @(posedge clk);
    #1;
    vOut    = rdValidV[d];
    dOut    = getRd(d);
    rdEn[d] = 1'b0;
  endtask

  initial begin
    nAssert = 0;
    nFail   = 0;
    vecs[0] = '{0, KEY1, 10, RK10K1, 11};
    vecs[1] = '{0, KEY1, 1,  128'ha0fafe1788542cb123a339392a6c7605, 11};
    vecs[2] = '{0, KEY2, 0,  128'h000102030405060708090a0b0c0d0e0f, 11};
    vecs[3] = '{0, KEY2, 10, RK10K2, 11};
    vecs[4] = '{1, KEY6, 12, 128'he98ba06f448c773c8ecc720401002202, 9};
    vecs[5] = '{1, KEY6, 0,  128'h8e73b0f7da0e6452c810f32b809079e5, 9};
    vecs[6] = '{2, KEY8, 14, 128'hfe4890d1e6188d0b046df344706c631e, 8};
    vecs[7] = '{2, KEY8, 1,  128'h1f352c073b6108d72d9810a30914dff4, 8};

    rst_n    = 1'b0;
    key4     = '0;
    key6     = '0;
    key8     = '0;
    keyValid = 3'b000;
    rdEn     = 3'b000;
    for (int d = 0; d < 3; d++) rdIdx[d] = 4'd0;
`ifdef KEY_SCHED_ZEROIZE_EN
    zeroizeV = 3'b000;
`endif
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset status dut%0d", d), {123'd0, status(d)}, {123'd0, 5'b10000});
      check($sformatf("reset rd_data dut%0d", d), getRd(d), 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Table of key / round-key vectors.
    for (int i = 0; i < 8; i++) begin
      loadKey(vecs[i].dut, vecs[i].key, vecs[i].doneAt, $sformatf("vec%0d", i));
      doRead(vecs[i].dut, vecs[i].idx, v, data);
      check($sformatf("vec%0d rd_valid", i), {127'd0, v}, 128'd1);
      check($sformatf("vec%0d rd_data", i), data, vecs[i].exp);
    end

    // Out-of-range indices: no valid, rd_data keeps the last round key.
    doRead(0, 11, v, data);
    check("idx11 rd_valid", {127'd0, v}, 128'd0);
    check("idx11 rd_data hold", data, RK10K2);
    doRead(0, 15, v, data);
    check("idx15 rd_valid", {127'd0, v}, 128'd0);

    // Reload in READY with a simultaneous read of index 10 (old schedule is KEY2).
    @(negedge clk);
    setKey(0, KEY1);
    keyValid[0] = 1'b1;
    rdEn[0]     = 1'b1;
    rdIdx[0]    = 4'd10;
    @(posedge clk);
    #1;
    keyValid = 3'b000;
    rdEn     = 3'b000;
    check("reload rd_valid", {127'd0, rdValidV[0]}, 128'd1);
    check("reload old rk10", rdData0, RK10K2);
    check("reload keys_ready", {127'd0, keysReadyV[0]}, 128'd0);
    check("reload busy", {127'd0, busyV[0]}, 128'd1);
    check("reload key_ready", {127'd0, keyReadyV[0]}, 128'd0);
    // A key offer and a read during EXPAND must both be ignored.
    @(negedge clk);
    setKey(0, KEY2);
    keyValid[0] = 1'b1;
    rdEn[0]     = 1'b1;
    rdIdx[0]    = 4'd10;
    @(posedge clk);
    #1;
    cnt      = 1;
    keyValid = 3'b000;
    rdEn     = 3'b000;
    check("expand read rd_valid", {127'd0, rdValidV[0]}, 128'd0);
    check("expand rd_data hold", rdData0, RK10K2);
    seen = 1'b0;
    while (!seen && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
      if (doneV[0]) seen = 1'b1;
    end
    check("reload done latency", 128'(cnt), 128'd11);
    @(posedge clk);
    #1;
    check("done pulse width", {127'd0, doneV[0]}, 128'd0);
    check("keys_ready level", {127'd0, keysReadyV[0]}, 128'd1);
    doRead(0, 10, v, data);
    check("new rk10", data, RK10K1);
    doRead(0, 0, v, data);
    check("new rk0", data, KEY1[255:128]);

`ifdef KEY_SCHED_ZEROIZE_EN
    // Zeroize in READY.
    @(negedge clk);
    zeroizeV[0] = 1'b1;
    @(posedge clk);
    #1;
    zeroizeV[0] = 1'b0;
    check("zeroize rd_data", rdData0, 128'd0);
    check("zeroize status", {123'd0, status(0)}, {123'd0, 5'b10000});
    doRead(0, 0, v, data);
    check("zeroize read rd_valid", {127'd0, v}, 128'd0);
    // Zeroize wins over a simultaneous key handshake.
    @(negedge clk);
    zeroizeV[0] = 1'b1;
    setKey(0, KEY1);
    keyValid[0] = 1'b1;
    @(posedge clk);
    #1;
    zeroizeV[0] = 1'b0;
    keyValid    = 3'b000;
    check("zeroize priority busy", {127'd0, busyV[0]}, 128'd0);
    loadKey(0, KEY1, 11, "post-zeroize");
    doRead(0, 10, v, data);
    check("post-zeroize rk10", data, RK10K1);
`endif

    // Reset mid-expansion aborts the schedule.
    @(negedge clk);
    setKey(0, KEY2);
    keyValid[0] = 1'b1;
    @(posedge clk);
    #1;
    keyValid = 3'b000;
    repeat (4) @(posedge clk);
    #1;
    check("abort busy before reset", {127'd0, busyV[0]}, 128'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort status", {123'd0, status(0)}, {123'd0, 5'b10000});
    check("abort rd_data", rdData0, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (keysReadyV[0] || doneV[0]) seen = 1'b1;
    end
    check("abort never ready", {127'd0, seen}, 128'd0);
    doRead(0, 0, v, data);
    check("abort read rd_valid", {127'd0, v}, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
